// File: rtl/he_pkg.sv
// Shared constants and FSM encodings for the HE LUT remap block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package he_pkg;

  localparam int PIX_W            = 8;
  localparam int LUT_DEPTH        = 256;
  localparam int LUT_AW           = 8;
  localparam int DEF_IMAGE_WIDTH  = 660;
  localparam int DEF_IMAGE_HEIGHT = 440;
  localparam int DEF_NUM_PIXELS   = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
  // Pixel index counter width; 19 bits covers 290400 pixels.
  localparam int CNT_W            = 19;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_REMAP = 2'd2;

endpackage

// File: rtl/he_lut_ram.sv
// 256x8 transform table: one synchronous write port, one synchronous read port.
// Latency: read data appears one clock after rd_en.
// Backpressure: read register holds its value whenever rd_en is low.
module he_lut_ram
  import he_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [LUT_AW-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_dat,
  input  logic              rd_en,
  input  logic [LUT_AW-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_dat
);

  // Table storage is deliberately not reset; only the read register is.
  logic [PIX_W-1:0] mem [LUT_DEPTH];
  logic [PIX_W-1:0] rd_dat_q;
  logic [PIX_W-1:0] rd_dat_d;

  // Table write from the load sequencer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Read register only updates on a new lookup so a stalled output stays stable.
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) begin
      rd_dat_d = mem[rd_addr];
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/he_lut_remap.sv
// Captures the HE transform table after he_done rises, then remaps one frame of pixels through it.
// Latency: 1 clock from pix_in accept to pix_out; throughput 1 pixel/clock.
// Backpressure: pix_ready = !out_valid | out_ready in REMAP; optional HE_LUT_MONO_CHECK_EN adds lut_err.
module he_lut_remap
  import he_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             he_done,
  input  logic [PIX_W-1:0] he_tbl,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             pix_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] pix_out,
  input  logic             out_ready,
  output logic             out_eol,
  output logic             frame_done,
  output logic             tbl_loaded,
  output logic             lut_err
);

  localparam int NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int COL_W      = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] NUM_PIX_C = CNT_W'(NUM_PIXELS);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMAGE_WIDTH - 1);

  logic              he_done_q;
  state_t            state_q, state_d;
  logic [LUT_AW-1:0] ld_addr_q, ld_addr_d;
  logic              tbl_loaded_q, tbl_loaded_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              frame_done_q, frame_done_d;

  logic              start_ok;
  logic              accept;
  logic              handoff;
  logic              wr_en;
  logic [LUT_AW-1:0] wr_addr;

  // Entry 0 arrives in the same cycle as the he_done edge, so it is written while still
  // in IDLE; the load counter then carries entries 1..255. Edges outside IDLE are ignored.
  always_comb begin
    start_ok  = he_done && !he_done_q && (state_q == ST_IDLE);
    // Input side stops once a full frame has been taken, so no pixel leaks into the next frame.
    pix_ready = (state_q == ST_REMAP) && (in_cnt_q != NUM_PIX_C) && (!out_valid_q || out_ready);
    accept    = pix_valid && pix_ready;
    handoff   = out_valid_q && out_ready;
    wr_en     = start_ok || (state_q == ST_LOAD);
    wr_addr   = start_ok ? '0 : ld_addr_q;
  end

  // Next-state logic for the FSM, load counter, output valid and frame counters.
  always_comb begin
    state_d      = state_q;
    ld_addr_d    = ld_addr_q;
    tbl_loaded_d = tbl_loaded_q;
    out_valid_d  = out_valid_q;
    pix_cnt_d    = pix_cnt_q;
    in_cnt_d     = in_cnt_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d      = ST_LOAD;
          ld_addr_d    = LUT_AW'(1);
          tbl_loaded_d = 1'b0;
        end
      end
      ST_LOAD: begin
        ld_addr_d = ld_addr_q + 1'b1;
        if (ld_addr_q == '1) begin
          state_d      = ST_REMAP;
          tbl_loaded_d = 1'b1;
        end
      end
      ST_REMAP: begin
        if (accept) begin
          in_cnt_d    = in_cnt_q + 1'b1;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
        if (handoff) begin
          if (pix_cnt_q == LAST_PIX) begin
            state_d      = ST_IDLE;
            out_valid_d  = 1'b0;
            pix_cnt_d    = '0;
            in_cnt_d     = '0;
            col_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
            col_d     = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and counter registers; reset drops any in-flight load or frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      he_done_q    <= 1'b0;
      state_q      <= ST_IDLE;
      ld_addr_q    <= '0;
      tbl_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      pix_cnt_q    <= '0;
      in_cnt_q     <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      he_done_q    <= he_done;
      state_q      <= state_d;
      ld_addr_q    <= ld_addr_d;
      tbl_loaded_q <= tbl_loaded_d;
      out_valid_q  <= out_valid_d;
      pix_cnt_q    <= pix_cnt_d;
      in_cnt_q     <= in_cnt_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
    end
  end

  he_lut_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (he_tbl),
    .rd_en   (accept),
    .rd_addr (pix_in),
    .rd_dat  (pix_out)
  );

`ifdef HE_LUT_MONO_CHECK_EN
  logic             lut_err_q, lut_err_d;
  logic [PIX_W-1:0] prev_tbl_q, prev_tbl_d;

  // The CDF map must be non-decreasing; a drop between consecutive entries is flagged
  // sticky until the next load starts. Capture itself is unaffected.
  always_comb begin
    lut_err_d  = lut_err_q;
    prev_tbl_d = prev_tbl_q;
    if (start_ok) begin
      lut_err_d = 1'b0;
    end
    if ((state_q == ST_LOAD) && (he_tbl < prev_tbl_q)) begin
      lut_err_d = 1'b1;
    end
    if (wr_en) begin
      prev_tbl_d = he_tbl;
    end
  end

  // Monotonicity checker registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      lut_err_q  <= 1'b0;
      prev_tbl_q <= '0;
    end else begin
      lut_err_q  <= lut_err_d;
      prev_tbl_q <= prev_tbl_d;
    end
  end

  assign lut_err = lut_err_q;
`else
  assign lut_err = 1'b0;
`endif

  assign out_valid  = out_valid_q;
  assign out_eol    = out_valid_q && (col_q == LAST_COL);
  assign frame_done = frame_done_q;
  assign tbl_loaded = tbl_loaded_q;

endmodule

// File: tb/tb_he_lut_remap.sv
// Directed bench for he_lut_remap on a reduced 8x4 frame.
// Latency: checks 1-clock accept-to-output timing and frame_done pulse placement.
// Backpressure: checks pix_ready gating and output hold while out_ready is low.
module tb_he_lut_remap;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NUM  = W * H;
  localparam int MAXC = 4 * NUM + 40;
`ifdef HE_LUT_MONO_CHECK_EN
  localparam logic MONO = 1'b1;
`else
  localparam logic MONO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       he_done;
  logic [7:0] he_tbl;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic       pix_ready;
  logic       out_valid;
  logic [7:0] pix_out;
  logic       out_ready;
  logic       out_eol;
  logic       frame_done;
  logic       tbl_loaded;
  logic       lut_err;

  logic [7:0] tbl     [256];
  logic [7:0] pix_vec [NUM];
  int n_asrt;
  int n_fail;

  always #5 clk = ~clk;

  he_lut_remap #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .he_done    (he_done),
    .he_tbl     (he_tbl),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .pix_ready  (pix_ready),
    .out_valid  (out_valid),
    .pix_out    (pix_out),
    .out_ready  (out_ready),
    .out_eol    (out_eol),
    .frame_done (frame_done),
    .tbl_loaded (tbl_loaded),
    .lut_err    (lut_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams tbl[] starting on the he_done edge; abort_at >= 0 resets mid-load.
  // he_done is left high on a full load; the caller decides when to drop it.
  task automatic load_table(input int abort_at);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        chk("mid_load_loaded", tbl_loaded, 1'b0);
        reset   = 1'b1;
        he_done = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        pix_valid = 1'b1;
        pix_in    = 8'h00;
        #1;
        chk("abort_loaded", tbl_loaded, 1'b0);
        chk("abort_ready", pix_ready, 1'b0);
        @(negedge clk);
        chk("abort_idle_ready", pix_ready, 1'b0);
        chk("abort_idle_valid", out_valid, 1'b0);
        pix_valid = 1'b0;
        return;
      end
      he_done = 1'b1;
      he_tbl  = tbl[k];
      if (k == 255) chk("loaded_early", tbl_loaded, 1'b0);
    end
    @(negedge clk);
    chk("loaded", tbl_loaded, 1'b1);
  endtask

  // Drives one frame of pix_vec[] and checks every output against tbl[].
  task automatic run_frame(input int st_at, input int st_len, input bit bubble, input int edge_at);
    int   in_idx;
    int   out_idx;
    int   fd_cnt;
    logic exp_v;
    logic prev_stall;
    logic [7:0] prev_out;
    logic acc;
    in_idx = 0; out_idx = 0; fd_cnt = 0; exp_v = 1'b0; prev_stall = 1'b0; prev_out = 8'h00;
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      @(negedge clk);
      chk("out_valid", out_valid, exp_v);
      if (prev_stall) chk("hold_dat", pix_out, prev_out);
      if (frame_done) fd_cnt++;
      out_ready = !(cyc >= st_at && cyc < st_at + st_len);
      pix_valid = (in_idx < NUM) && !(bubble && (cyc % 5 == 2));
      pix_in    = (in_idx < NUM) ? pix_vec[in_idx] : 8'h00;
      if (cyc == edge_at) begin
        he_done = 1'b1;
        he_tbl  = 8'hA5;
      end
      if (cyc == edge_at + 3) he_done = 1'b0;
      #1;
      if (in_idx < NUM) chk("pix_ready", pix_ready, !out_valid || out_ready);
      acc = pix_valid && pix_ready;
      if (out_valid && out_ready) begin
        chk("pix_out", pix_out, tbl[pix_vec[out_idx]]);
        chk("out_eol", out_eol, (out_idx % W) == (W - 1));
        out_idx++;
      end
      exp_v      = acc || (out_valid && !out_ready);
      prev_stall = out_valid && !out_ready;
      prev_out   = pix_out;
      if (acc) in_idx++;
      if (out_idx == NUM) break;
    end
    pix_valid = 1'b0;
    out_ready = 1'b1;
    chk("frame_len", out_idx, NUM);
    chk("fd_early", fd_cnt, 0);
    @(negedge clk);
    chk("fd_pulse", frame_done, 1'b1);
    @(negedge clk);
    chk("fd_width", frame_done, 1'b0);
  endtask

  initial begin
    n_asrt = 0; n_fail = 0;
    reset = 1'b1; he_done = 1'b0; he_tbl = 8'h00;
    pix_valid = 1'b1; pix_in = 8'h33; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pix_ready", pix_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_eol", out_eol, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_tbl_loaded", tbl_loaded, 1'b0);
    chk("rst_lut_err", lut_err, 1'b0);
    chk("rst_pix_out", pix_out, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_table_ready", pix_ready, 1'b0);
    pix_valid = 1'b0;

    // 1: identity table
    for (int k = 0; k < 256; k++) tbl[k] = 8'(k);
    for (int i = 0; i < NUM; i++) pix_vec[i] = 8'((i * 29 + 7) % 256);
    load_table(-1);
    he_done = 1'b0;
    run_frame(-1, 0, 1'b0, -1);
    pix_valid = 1'b1;
    pix_in    = 8'h10;
    repeat (3) begin
      @(negedge clk);
      chk("post_frame_ready", pix_ready, 1'b0);
      chk("post_frame_valid", out_valid, 1'b0);
    end
    chk("post_frame_loaded", tbl_loaded, 1'b1);
    pix_valid = 1'b0;

    // 2: inverted table with input bubbles
    for (int k = 0; k < 256; k++) tbl[k] = 8'(255 - k);
    for (int i = 0; i < NUM; i++) pix_vec[i] = 8'((i * 53 + 1) % 256);
    pix_vec[0] = 8'h10; pix_vec[1] = 8'h00; pix_vec[2] = 8'hFF;
    load_table(-1);
    he_done = 1'b0;
    run_frame(-1, 0, 1'b1, -1);

    // 3: five-cycle backpressure mid-row
    for (int i = 0; i < NUM; i++) pix_vec[i] = 8'((i * 11 + 200) % 256);
    load_table(-1);
    he_done = 1'b0;
    run_frame(W + 3, 5, 1'b0, -1);

    // 4: reset at entry 100, then full reload with a different table
    for (int k = 0; k < 256; k++) tbl[k] = 8'(k) ^ 8'h5A;
    load_table(100);
    for (int k = 0; k < 256; k++) tbl[k] = 8'(k >> 1);
    for (int i = 0; i < NUM; i++) pix_vec[i] = 8'((i * 8 + 3) % 256);
    load_table(-1);
    he_done = 1'b0;
    run_frame(-1, 0, 1'b0, -1);

    // 5: held he_done loads once; an edge during REMAP is ignored
    for (int k = 0; k < 256; k++) tbl[k] = (k < 252) ? 8'(k + 3) : 8'hFF;
    for (int i = 0; i < NUM; i++) pix_vec[i] = 8'((i * 37 + 90) % 256);
    load_table(-1);
    run_frame(-1, 0, 1'b0, -1);
    repeat (5) @(negedge clk);
    pix_valid = 1'b1;
    #1;
    chk("held_no_reload", tbl_loaded, 1'b1);
    chk("held_idle_ready", pix_ready, 1'b0);
    pix_valid = 1'b0;
    @(negedge clk);
    he_done = 1'b0;
    for (int k = 0; k < 256; k++) tbl[k] = 8'(k) | 8'h01;
    load_table(-1);
    he_done = 1'b0;
    run_frame(W + 6, 2, 1'b0, 12);
    chk("edge_ignored_loaded", tbl_loaded, 1'b1);

    // 6: monotonicity flag
    for (int k = 0; k < 256; k++) tbl[k] = 8'(k);
    tbl[50] = 8'h40; tbl[51] = 8'h3F;
    for (int i = 0; i < NUM; i++) pix_vec[i] = 8'((i * 3 + 40) % 256);
    load_table(-1);
    he_done = 1'b0;
    chk("mono_err", lut_err, MONO);
    run_frame(-1, 0, 1'b0, -1);
    chk("mono_sticky", lut_err, MONO);
    for (int k = 0; k < 256; k++) tbl[k] = 8'(k);
    load_table(-1);
    he_done = 1'b0;
    chk("mono_clear", lut_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
